// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: expands each one-hot solver move into a vertical
// and a horizontal motion command, and passes UART commands through when idle.
module tour_cmd_seq #(
   parameter int unsigned NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic [7:0]  resp
);

   localparam int unsigned IW = 5;
   localparam int unsigned CW = 16;
   localparam int unsigned HW = 8;
   localparam int unsigned SW = 4;

   localparam logic [3:0]    OP_MOVE = 4'h2;
   localparam logic [3:0]    OP_FANF = 4'h3;
   localparam logic [HW-1:0] HEAD_N  = 8'h00;
   localparam logic [HW-1:0] HEAD_W  = 8'h3F;
   localparam logic [HW-1:0] HEAD_S  = 8'h7F;
   localparam logic [HW-1:0] HEAD_E  = 8'hBF;
   localparam logic [7:0]    RESP_IDLE = 8'hA5;
   localparam logic [7:0]    RESP_BUSY = 8'h5A;

   typedef enum logic [2:0] {IDLE, VERT, VWCLR, VWRSP, HORZ, HWCLR, HWRSP} state_t;

   state_t        state, nxt_state;
   logic [IW-1:0] idx_q, nxt_idx;
   logic [CW-1:0] cmd_q, nxt_cmd;
   logic          rdy_q, nxt_rdy;
   logic [HW-1:0] v_head, h_head;
   logic [SW-1:0] v_sq, h_sq;
   logic          last_mv;
   logic          adv;

   assign last_mv = (idx_q == IW'(NUM_MOVES - 1));

   // Move decode: lowest set bit wins; all-zero decodes to N/0 for both legs.
   always_comb begin
      v_head = HEAD_N;
      v_sq   = 4'd0;
      h_head = HEAD_N;
      h_sq   = 4'd0;
      if (move[0]) begin
         v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1;
      end else if (move[1]) begin
         v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1;
      end else if (move[2]) begin
         v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2;
      end else if (move[3]) begin
         v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2;
      end else if (move[4]) begin
         v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1;
      end else if (move[5]) begin
         v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1;
      end else if (move[6]) begin
         v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2;
      end else if (move[7]) begin
         v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx_q <= '0;
         cmd_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         state <= nxt_state;
         idx_q <= nxt_idx;
         cmd_q <= nxt_cmd;
         rdy_q <= nxt_rdy;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx_q;
      nxt_cmd   = cmd_q;
      nxt_rdy   = rdy_q;
      adv       = 1'b0;
      case (state)
         IDLE:  if (start_tour) nxt_state = VERT;
         VERT: begin
            nxt_cmd   = {OP_MOVE, v_head, v_sq};
            nxt_rdy   = 1'b1;
            nxt_state = VWCLR;
         end
         VWCLR: if (clr_cmd_rdy) begin
            nxt_rdy   = 1'b0;
            nxt_state = send_resp ? HORZ : VWRSP;
         end
         VWRSP: if (send_resp) nxt_state = HORZ;
         HORZ: begin
            nxt_cmd   = {OP_FANF, h_head, h_sq};
            nxt_rdy   = 1'b1;
            nxt_state = HWCLR;
         end
         HWCLR: if (clr_cmd_rdy) begin
            nxt_rdy   = 1'b0;
            nxt_state = HWRSP;
            adv       = send_resp;
         end
         HWRSP: adv = send_resp;
         default: nxt_state = IDLE;
      endcase
      // Move advance: wrap to IDLE after the final move, else fetch the next one.
      if (adv) begin
         if (last_mv) begin
            nxt_idx   = '0;
            nxt_state = IDLE;
         end else begin
            nxt_idx   = idx_q + IW'(1);
            nxt_state = VERT;
         end
      end
   end

   assign mv_indx = idx_q;
   assign cmd     = (state == IDLE) ? cmd_UART : cmd_q;
   assign cmd_rdy = (state == IDLE) ? cmd_rdy_UART : rdy_q;
   assign resp    = ((state == IDLE) ||
                     (((state == HWCLR) || (state == HWRSP)) && last_mv)) ? RESP_IDLE : RESP_BUSY;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: a model consumer handshakes each leg and a
// scoreboard queue holds the commands predicted from the move table.
module tb_tour_cmd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;

   int n_assert = 0;
   int n_fail   = 0;
   int legs     = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  tour_mv[24];

   // Leg tables per move bit: vertical heading/squares, horizontal heading/squares.
   localparam logic [7:0] VH [8] = '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00};
   localparam logic [3:0] VS [8] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1};
   localparam logic [7:0] HH [8] = '{8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'hBF, 8'hBF, 8'hBF};
   localparam logic [3:0] HS [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2};

   always #5 clk = ~clk;

   assign move = (mv_indx < 5'd24) ? tour_mv[mv_indx] : 8'h00;

   tour_cmd_seq #(.NUM_MOVES(24)) dut (
      .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
      .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
      .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
      v = 16'h2000;
      h = 16'h3000;
      for (int b = 7; b >= 0; b--)
         if (m[b]) begin
            v = {4'h2, VH[b], VS[b]};
            h = {4'h3, HH[b], HS[b]};
         end
   endfunction

   task automatic push_move(input int idx);
      logic [15:0] v, h;
      model(tour_mv[idx], v, h);
      exp_q.push_back(v);
      exp_q.push_back(h);
   endtask

   task automatic start_run();
      start_tour = 1'b1;
      @(posedge clk); #1;
      start_tour = 1'b0;
   endtask

   // Wait one edge for the leg (strict latency), then check it and handshake it.
   task automatic consume_leg(input bit horz, input bit coinc, input int idx, input bit do_resp);
      logic [15:0] exp;
      logic [7:0]  exp_resp;
      int waited;
      exp = 16'hxxxx;
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      exp_resp = (horz && idx == 23) ? 8'hA5 : 8'h5A;
      @(posedge clk); #1;
      chk("cmd_rdy_latency", 16'(cmd_rdy), 16'd1);
      waited = 0;
      while (cmd_rdy !== 1'b1 && waited < 8) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("cmd", cmd, exp);
      chk("resp_clr", 16'(resp), 16'(exp_resp));
      legs++;
      repeat (idx % 3) begin
         @(posedge clk); #1;
         chk("cmd_rdy_hold", 16'(cmd_rdy), 16'd1);
      end
      clr_cmd_rdy = 1'b1;
      send_resp   = coinc;
      start_tour  = (idx == 5);
      @(posedge clk); #1;
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
      start_tour  = 1'b0;
      chk("cmd_rdy_after_clr", 16'(cmd_rdy), 16'd0);
      if (!coinc && do_resp) begin
         chk("resp_rsp", 16'(resp), 16'(exp_resp));
         send_resp = 1'b1;
         @(posedge clk); #1;
         send_resp = 1'b0;
      end
   endtask

   task automatic run_move(input int idx, input bit vc, input bit hc);
      push_move(idx);
      consume_leg(1'b0, vc, idx, 1'b1);
      consume_leg(1'b1, hc, idx, 1'b1);
      chk("mv_indx", 16'(mv_indx), (idx == 23) ? 16'd0 : 16'(idx + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      tour_mv[0] = 8'h01; tour_mv[1] = 8'h40; tour_mv[2] = 8'h00; tour_mv[3] = 8'h0C;
      for (int i = 4; i < 24; i++)
         tour_mv[i] = 8'(1 << (i % 8)) | ((i % 5 == 0) ? 8'h80 : 8'h00);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
      chk("rst_mv_indx", 16'(mv_indx), 16'd0);
      chk("rst_resp", 16'(resp), 16'h00A5);
      chk("rst_cmd", cmd, 16'h0000);

      // Idle pass-through, same cycle
      cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1;
      #1;
      chk("pass_cmd", cmd, 16'h2BF3);
      chk("pass_rdy", 16'(cmd_rdy), 16'd1);
      chk("pass_resp", 16'(resp), 16'h00A5);

      // Full tour with UART traffic asserted throughout
      cmd_UART = 16'hFFFF;
      legs = 0;
      start_run();
      for (int i = 0; i < 24; i++)
         run_move(i, (i % 2 == 1), (i % 3 == 1) && (i != 23));
      chk("legs_issued", 16'(legs), 16'd48);
      chk("end_mv_indx", 16'(mv_indx), 16'd0);
      chk("end_pass_rdy", 16'(cmd_rdy), 16'd1);
      chk("end_pass_cmd", cmd, 16'hFFFF);
      chk("end_resp", 16'(resp), 16'h00A5);
      chk("queue_empty_a", 16'(exp_q.size()), 16'd0);

      // Random tour, reset while waiting for the response of move 10's horizontal leg
      for (int i = 0; i < 24; i++) tour_mv[i] = 8'($urandom_range(0, 255));
      start_run();
      for (int i = 0; i < 10; i++) run_move(i, 1'($urandom_range(0, 1)), 1'b0);
      push_move(10);
      consume_leg(1'b0, 1'b0, 10, 1'b1);
      consume_leg(1'b1, 1'b0, 10, 1'b0);
      chk("pre_rst_mv_indx", 16'(mv_indx), 16'd10);
      chk("pre_rst_resp", 16'(resp), 16'h005A);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_mv_indx", 16'(mv_indx), 16'd0);
      chk("mid_rst_rdy", 16'(cmd_rdy), 16'd1);
      chk("mid_rst_cmd", cmd, 16'hFFFF);
      chk("mid_rst_resp", 16'(resp), 16'h00A5);
      cmd_rdy_UART = 1'b0;
      #1;
      chk("mid_rst_rdy_low", 16'(cmd_rdy), 16'd0);

      // Restart from move 0 after the abandoned tour
      for (int i = 0; i < 24; i++) tour_mv[i] = 8'($urandom_range(0, 255));
      legs = 0;
      start_run();
      for (int i = 0; i < 24; i++)
         run_move(i, 1'($urandom_range(0, 1)), (i != 23) && 1'($urandom_range(0, 1)));
      chk("legs_issued_b", 16'(legs), 16'd48);
      chk("end_b_rdy", 16'(cmd_rdy), 16'd0);
      chk("queue_empty_b", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
